// File: rtl/mac_sa_queue.sv
// Show-ahead source-MAC FIFO feeding the learning arbiter, with sticky overflow and drop counter.
// Optional build macro SA_QUEUE_DEDUP_EN drops an SA equal to the last accepted one.
module mac_sa_queue #(
    parameter int unsigned pDEPTH   = 4,
    parameter logic [1:0]  pPORT_ID = 2'd0
) (
    input  logic        iclk,
    input  logic        irst_n,
    input  logic        i_newsa,
    input  logic [47:0] i_sa,
    input  logic        i_grant,
    input  logic        i_clr_ovf,
    output logic        o_req,
    output logic [47:0] o_sa,
    output logic [1:0]  o_port_num,
    output logic [4:0]  o_level,
    output logic        o_overflow,
    output logic [7:0]  o_drop_cnt
);

    localparam int unsigned PTR_W = (pDEPTH > 1) ? $clog2(pDEPTH) : 1;
    localparam int unsigned LVL_W = 5;
    localparam int unsigned SA_W  = 48;
    localparam int unsigned CNT_W = 8;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(pDEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [SA_W-1:0]  mem_q [pDEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0] cnt_base;

    logic pop_c, push_c, drop_c, dup_c, full_c;

`ifdef SA_QUEUE_DEDUP_EN
    logic [SA_W-1:0] last_sa_q, last_sa_d;
    logic            last_vld_q, last_vld_d;

    assign dup_c = last_vld_q && (i_sa == last_sa_q);

    // Remember the most recently accepted SA for duplicate suppression.
    always_comb begin
        last_sa_d  = last_sa_q;
        last_vld_d = last_vld_q;
        if (push_c) begin
            last_sa_d  = i_sa;
            last_vld_d = 1'b1;
        end
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            last_sa_q  <= '0;
            last_vld_q <= 1'b0;
        end else begin
            last_sa_q  <= last_sa_d;
            last_vld_q <= last_vld_d;
        end
    end
`else
    assign dup_c = 1'b0;
`endif

    assign full_c = (level_q == FULL_LVL);
    assign pop_c  = i_grant && (level_q != '0);
    assign push_c = i_newsa && !dup_c && (!full_c || pop_c);
    assign drop_c = i_newsa && !dup_c && full_c && !pop_c;

    // Pointer, level and overflow bookkeeping; a clear in the same cycle as a drop yields count 1.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        cnt_base   = i_clr_ovf ? '0 : drop_cnt_q;
        drop_cnt_d = cnt_base;
        overflow_d = (overflow_q && !i_clr_ovf) || drop_c;
        if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push_c && !pop_c)      level_d = level_q + LVL_W'(1);
        else if (pop_c && !push_c) level_d = level_q - LVL_W'(1);
        if (drop_c && (cnt_base != CNT_MAX)) drop_cnt_d = cnt_base + CNT_W'(1);
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage is not reset; validity is tracked by the level alone.
    always_ff @(posedge iclk) begin
        if (push_c) mem_q[wr_ptr_q] <= i_sa;
    end

    assign o_req      = (level_q != '0);
    assign o_sa       = mem_q[rd_ptr_q];
    assign o_port_num = o_req ? pPORT_ID : 2'd0;
    assign o_level    = level_q;
    assign o_overflow = overflow_q;
    assign o_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_mac_sa_queue.sv
// Directed plus randomized bench for mac_sa_queue against a queue-based reference model.
module tb_mac_sa_queue;

    localparam int unsigned DEPTH = 4;
    localparam logic [1:0]  PORT  = 2'd2;

    logic        iclk = 1'b0;
    logic        irst_n = 1'b0;
    logic        i_newsa = 1'b0;
    logic [47:0] i_sa = '0;
    logic        i_grant = 1'b0;
    logic        i_clr_ovf = 1'b0;
    logic        o_req;
    logic [47:0] o_sa;
    logic [1:0]  o_port_num;
    logic [4:0]  o_level;
    logic        o_overflow;
    logic [7:0]  o_drop_cnt;

    int checks = 0;
    int failures = 0;

    logic [47:0] mq[$];
    logic        m_ovf = 1'b0;
    int          m_cnt = 0;
    logic [47:0] m_last = '0;
    logic        m_last_vld = 1'b0;

    mac_sa_queue #(.pDEPTH(DEPTH), .pPORT_ID(PORT)) dut (
        .iclk(iclk), .irst_n(irst_n), .i_newsa(i_newsa), .i_sa(i_sa),
        .i_grant(i_grant), .i_clr_ovf(i_clr_ovf), .o_req(o_req), .o_sa(o_sa),
        .o_port_num(o_port_num), .o_level(o_level), .o_overflow(o_overflow),
        .o_drop_cnt(o_drop_cnt)
    );

    always #5 iclk = ~iclk;

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = mq.size();
        chk({tag, ".req"}, 48'(o_req), 48'(n != 0));
        chk({tag, ".level"}, 48'(o_level), 48'(n));
        chk({tag, ".port"}, 48'(o_port_num), (n != 0) ? 48'(PORT) : 48'd0);
        chk({tag, ".ovf"}, 48'(o_overflow), 48'(m_ovf));
        chk({tag, ".cnt"}, 48'(o_drop_cnt), 48'(m_cnt));
        if (n != 0) chk({tag, ".sa"}, o_sa, mq[0]);
    endtask

    function automatic void model_reset();
        mq.delete();
        m_ovf = 1'b0;
        m_cnt = 0;
        m_last_vld = 1'b0;
    endfunction

    // One clock of the reference: decide everything from pre-edge state, then apply.
    function automatic void model_step(input logic nw, input logic [47:0] sa,
                                       input logic gr, input logic clr);
        bit dup, pop, full, push, drop;
`ifdef SA_QUEUE_DEDUP_EN
        dup = m_last_vld && (sa == m_last);
`else
        dup = 1'b0;
`endif
        full = (mq.size() == DEPTH);
        pop  = gr && (mq.size() != 0);
        push = nw && !dup && (!full || pop);
        drop = nw && !dup && full && !pop;
        if (clr) begin
            m_ovf = 1'b0;
            m_cnt = 0;
        end
        if (drop) begin
            m_ovf = 1'b1;
            if (m_cnt < 255) m_cnt++;
        end
        if (pop) void'(mq.pop_front());
        if (push) begin
            mq.push_back(sa);
            m_last = sa;
            m_last_vld = 1'b1;
        end
    endfunction

    task automatic step(input logic nw, input logic [47:0] sa, input logic gr, input logic clr);
        @(negedge iclk);
        i_newsa = nw; i_sa = sa; i_grant = gr; i_clr_ovf = clr;
        model_step(nw, sa, gr, clr);
        @(posedge iclk);
        #1;
        i_newsa = 1'b0; i_grant = 1'b0; i_clr_ovf = 1'b0;
    endtask

    logic [47:0] sa_v;

    initial begin
        // Reset state, checked while reset is held.
        #2;
        model_reset();
        check_all("reset");
        @(negedge iclk);
        irst_n = 1'b1;

        // Single push then grant.
        step(1'b1, 48'h0011_2233_4455, 1'b0, 1'b0);
        check_all("one_push");
        chk("one_push.sa_const", o_sa, 48'h0011_2233_4455);
        step(1'b0, '0, 1'b1, 1'b0);
        check_all("one_pop");
        step(1'b0, '0, 1'b1, 1'b0);
        check_all("empty_grant");

        // Six pushes into a four-deep queue, then drain.
        for (int i = 0; i < 6; i++) begin
            sa_v = 48'h1000_0000_0000 + 48'(i);
            step(1'b1, sa_v, 1'b0, 1'b0);
            check_all("fill");
        end
        chk("fill.cnt_const", 48'(o_drop_cnt), 48'd2);
        for (int i = 0; i < 4; i++) begin
            chk("drain.order", o_sa, 48'h1000_0000_0000 + 48'(i));
            step(1'b0, '0, 1'b1, 1'b0);
            check_all("drain");
        end

        // Empty queue with push and grant together.
        step(1'b1, 48'h2000_0000_0001, 1'b1, 1'b0);
        check_all("empty_push_grant");

        // Clear together with a fresh drop: overflow stays, count restarts at 1.
        for (int i = 0; i < 4; i++) step(1'b1, 48'h2100_0000_0000 + 48'(i), 1'b0, 1'b0);
        check_all("refill");
        step(1'b1, 48'h2200_0000_0000, 1'b0, 1'b1);
        check_all("clr_with_drop");

        // Full queue, push+grant for 8 cycles across pointer wrap.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 48'h3000_0000_0000 + 48'(i), 1'b1, 1'b0);
            check_all("full_pushpop");
        end

        // Drain to three entries, then one-cycle reset mid-stream.
        step(1'b0, '0, 1'b1, 1'b0);
        check_all("to_three");
        @(negedge iclk);
        irst_n = 1'b0;
        i_newsa = 1'b1; i_sa = 48'h4444_4444_4444; i_grant = 1'b1;
        #1;
        model_reset();
        check_all("midreset");
        @(negedge iclk);
        irst_n = 1'b1;
        i_newsa = 1'b0; i_grant = 1'b0;
        check_all("after_reset");
        step(1'b1, 48'h5555_6666_7777, 1'b0, 1'b0);
        check_all("sole_entry");

        // Same SA twice back to back after a reset.
        @(negedge iclk);
        irst_n = 1'b0;
        #1;
        model_reset();
        @(negedge iclk);
        irst_n = 1'b1;
        step(1'b1, 48'hAA00_0000_0001, 1'b0, 1'b0);
        step(1'b1, 48'hAA00_0000_0001, 1'b0, 1'b0);
        check_all("repeat_sa");
`ifdef SA_QUEUE_DEDUP_EN
        chk("repeat_sa.level_const", 48'(o_level), 48'd1);
`else
        chk("repeat_sa.level_const", 48'(o_level), 48'd2);
`endif

        // 300 overflow drops saturate the counter, then clear.
        for (int i = 0; i < 4; i++) step(1'b1, 48'h6000_0000_0000 + 48'(i), 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) step(1'b1, 48'h7000_0000_0000 + 48'(i), 1'b0, 1'b0);
        check_all("saturate");
        chk("saturate.cnt_const", 48'(o_drop_cnt), 48'd255);
        step(1'b0, '0, 1'b0, 1'b1);
        check_all("clear");

        // Randomized traffic with a small SA pool so repeats occur.
        for (int i = 0; i < 600; i++) begin
            sa_v = 48'hB000_0000_0000 + 48'($urandom_range(0, 3));
            step(1'($urandom_range(0, 3) != 0), sa_v, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 31) == 0));
            check_all("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mac_sa_queue.md
MAC_SA_QUEUE -- requirements
Module: mac_sa_queue

Interface
REQ-001 Parameter pDEPTH, default 4, FIFO entry count; SHALL be a power of two in 2..16.
REQ-002 Parameter pPORT_ID, default 2'd0, ingress port number attached to every entry.
REQ-003 iclk  input  1  sole clock; all state SHALL change on its rising edge only.
REQ-004 irst_n  input  1  reset; SHALL be asynchronous and active-low.
REQ-005 i_newsa  input  1  one-cycle pulse from frame receiver: i_sa valid this cycle.
REQ-006 i_sa  input  48  source MAC address from frame receiver.
REQ-007 i_grant  input  1  arbiter accepts head entry this cycle.
REQ-008 i_clr_ovf  input  1  clears o_overflow and o_drop_cnt.
REQ-009 o_req  output  1  queue non-empty; head entry offered to arbiter.
REQ-010 o_sa  output  48  head-entry SA; valid only while o_req=1.
REQ-011 o_port_num  output  2  equals pPORT_ID while o_req=1, else 0.
REQ-012 o_level  output  5  current entry count, 0..pDEPTH.
REQ-013 o_overflow  output  1  sticky: at least one SA dropped because the queue was full.
REQ-014 o_drop_cnt  output  8  count of overflow drops, saturating.

Function
REQ-015 Push: i_newsa=1 and (o_level<pDEPTH or pop same cycle) SHALL write i_sa at write pointer; write pointer advances modulo pDEPTH.
REQ-016 Pop: i_grant=1 and o_req=1 SHALL advance read pointer modulo pDEPTH; i_grant with o_req=0 SHALL be ignored.
REQ-017 Show-ahead: o_sa SHALL present head entry combinationally from storage; no read latency.
REQ-018 Latency: push at edge N SHALL make o_req=1 and o_sa valid in cycle after edge N (empty queue).
REQ-019 o_req SHALL equal (o_level!=0); it SHALL stay high back-to-back across pops while entries remain.
REQ-020 Level: +1 on push only, -1 on pop only, unchanged on simultaneous push+pop or neither.
REQ-021 Full with simultaneous push+pop: both SHALL succeed; level stays pDEPTH; no drop.
REQ-022 Empty with simultaneous push+grant: push SHALL succeed, grant ignored; level becomes 1.
REQ-023 Full, push, no pop: i_sa SHALL be discarded, o_overflow set to 1, o_drop_cnt incremented saturating at 255.
REQ-024 i_clr_ovf=1 SHALL clear o_overflow and o_drop_cnt next edge; if an overflow drop occurs in the same cycle, o_overflow=1 and o_drop_cnt=1 after the edge.
REQ-025 Entry order SHALL be strict FIFO; pointer wrap SHALL not corrupt or reorder entries.

Reset
REQ-026 irst_n=0 SHALL immediately clear pointers, o_level=0, o_req=0, o_port_num=0, o_overflow=0, o_drop_cnt=0, dedup register invalid; storage contents need not clear.
REQ-027 Reset mid-operation SHALL discard all queued entries; i_newsa/i_grant during reset ignored.
REQ-028 First push allowed on first rising edge after irst_n deasserts.

Configuration
REQ-029 Macro SA_QUEUE_DEDUP_EN defined: a register SHALL hold the last accepted SA plus valid bit; i_newsa with i_sa equal to that register while valid SHALL be dropped silently (no push, no overflow, no count); accepted pushes update the register.
REQ-030 SA_QUEUE_DEDUP_EN undefined: no dedup register; every i_newsa SHALL be handled per REQ-015/REQ-023.

Verification
REQ-031 Reset, push SA 00:11:22:33:44:55 once -> next cycle o_req=1, o_sa=001122334455, o_level=1, o_port_num=pPORT_ID; grant -> o_req=0, o_level=0.
REQ-032 pDEPTH=4, push 6 distinct SAs no grant -> o_level=4, o_overflow=1, o_drop_cnt=2; four grants return first four SAs in order.
REQ-033 Full queue, push+grant same cycle for 8 cycles -> o_level stays 4, o_drop_cnt unchanged, outputs follow FIFO order across pointer wrap.
REQ-034 Push AA..01 twice consecutively -> with SA_QUEUE_DEDUP_EN o_level=1; without it o_level=2.
REQ-035 Queue holding 3 entries, irst_n low for one cycle mid-stream -> o_req=0, o_level=0 immediately; subsequent push appears as sole entry.
REQ-036 Force 300 overflow drops -> o_drop_cnt=255; i_clr_ovf pulse -> o_overflow=0, o_drop_cnt=0.
